multi_clock_divider: RTL
========================

# multi_clock_divider

Parametrised, multi-channel clock divider for the 100 MHz board oscillator. Each channel has a runtime-programmable divisor and produces a one-cycle tick enable plus a 50 % duty toggle output. Divisor changes are glitch-free, and a global sync strobe phase-aligns all channels. Sits between the oscillator pin and the display/scan logic, which use the ticks as clock enables rather than as derived clocks.

## Interface
- CHANNELS, 4, number of independent divider channels (≥1)
- WIDTH, 20, divisor and counter width in bits
- DEFAULT_DIV, 50000, divisor loaded into every channel at reset (1..2^WIDTH-1)
- CH_BITS, max(1, clog2(CHANNELS)), derived width of the channel select
- cmosClock  in  1  single system clock (100 MHz oscillator); all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  CHANNELS  per-channel run enable; low freezes that channel
- sync  in  1  one-cycle strobe; restarts all channels in phase
- cfgWrite  in  1  divisor write strobe
- cfgChannel  in  CH_BITS  target channel of the write
- cfgDivisor  in  WIDTH  new divisor; 0 halts the channel
- tickOut  out  CHANNELS  one-cycle pulse per divisor period
- clockOut  out  CHANNELS  toggles on each tick (period 2·divisor)
- pending  out  CHANNELS  a written divisor is waiting to take effect

## Operation
- Per-channel state: active divisor div, shadow divisor shd, pending flag, counter cnt[WIDTH-1:0], tick, level.
- Reset values: div = shd = DEFAULT_DIV; pending = 0; cnt = 0; tickOut = 0; clockOut = 0.
- Priority per cycle: reset > sync > counting. A cfgWrite is always captured into shd, except under reset.
- cfgWrite: shd[cfgChannel] ← cfgDivisor, pending ← 1. If cfgChannel ≥ CHANNELS, the write is ignored with no state change.
- Counting requires enable = 1 and div ≠ 0.
  - If cnt = div−1: cnt ← 0, tick ← 1, level ← ~level. If pending, div ← shd and pending ← 0.
  - Otherwise: cnt ← cnt+1, tick ← 0.
- Halted channel (div = 0): cnt held at 0, tick = 0, level held. When pending, div ← shd, cnt ← 0 and pending ← 0 on the next edge, so a halted channel restarts without needing a wrap.
- enable = 0: cnt, level and div frozen; tick = 0; writes still land in shd and remain pending.
- sync: every channel gets cnt ← 0, tick ← 0, level ← 0. Any pending shd is loaded into div and pending clears. A cfgWrite in the same cycle wins over the sync load for its channel: shd takes the new value and pending stays 1.
- Write coinciding with a wrap on the same channel: the wrap loads the old shd. The new value stays in shd with pending = 1 and applies at the following wrap.
- Arithmetic: div−1 is computed in WIDTH bits. It never underflows because the wrap compare is gated by div ≠ 0. cnt never exceeds div−1.

## Timing
- Outputs are fully registered, with no combinational path from inputs to outputs.
- With divisor N and enable held high from the cycle after reset deasserts, the first tick is high on edge N. Subsequent ticks come every N cycles, each exactly 1 cycle wide.
- N = 1: tickOut is constantly high and clockOut toggles every cycle.
- clockOut period is 2N and its edges coincide with tick assertion.
- A new divisor takes effect from the wrap following the write. The first period at the new rate starts the cycle after the wrap; no short or long glitch periods occur.
- pending rises 1 cycle after cfgWrite and falls in the cycle the divisor is applied.
- Reset asserted mid-count: all outputs take their reset values on the next edge, and any in-flight write is discarded.

## Structure
- Package clock_div_pkg: default CHANNELS/WIDTH/DEFAULT_DIV constants, OSC_HZ = 100_000_000, and a divisor-from-frequency constant function.
- Sub-module clock_div_channel holds one channel's div/shd/pending/cnt/tick/level. Top level: generate loop over CHANNELS, write decode of cfgChannel, sync fan-out.

## Test plan
- Reset, all enable = 1, DEFAULT_DIV overridden to 4 → tickOut high at cycles 4, 8, 12; clockOut toggles at the same cycles.
- Write ch1 divisor 3 while it runs at 5 → pending[1] high next cycle; old 5-cycle period completes, then ticks every 3 cycles; pending clears at that wrap.
- Write 0 to ch2, then 6 after 10 cycles → no ticks while halted; first tick 6 cycles after the restart load; clockOut level is held across the halt.
- sync at an arbitrary cycle with channels at divisors 2/3/4/5 → all cnt = 0 and clockOut = 0 next cycle; ticks realign at 2/3/4/5 cycles after sync.
- cfgWrite on the wrap cycle of ch0 (4 → 7), and separately with cfgChannel = CHANNELS → first write applies at the next wrap; second write changes no state.
- enable[3] low for 5 cycles mid-count, then reset asserted mid-period → tick period stretched by exactly 5; after reset, tickOut = clockOut = pending = 0 and counting restarts from 0.

Source files
------------

// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_div_pkg;

    localparam int unsigned DEF_CHANNELS = 4;
    localparam int unsigned DEF_WIDTH    = 20;
    localparam int unsigned DEF_DIV      = 50000;
    localparam int unsigned OSC_HZ       = 100_000_000;

    // Divisor that yields a tick rate of hz from the board oscillator (0 halts).
    function automatic int unsigned div_from_hz(input int unsigned hz);
        return (hz == 0) ? 0 : OSC_HZ / hz;
    endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: active/shadow divisor, counter, tick pulse and toggle level.
module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_div_i,
    output logic             tick_o,
    output logic             level_o,
    output logic             pending_o
);

    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;
    logic [WIDTH-1:0] div_last;
    logic             load_c;

    // Terminal count; only compared when div is non-zero, so no underflow matters.
    assign div_last = div_q - WIDTH'(1);

    // Next-state: sync beats counting; a write always lands in the shadow register.
    always_comb begin
        div_d     = div_q;
        shd_d     = shd_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
        level_d   = level_q;
        load_c    = 1'b0;

        if (sync_i) begin
            cnt_d   = '0;
            level_d = 1'b0;
            load_c  = pending_q;
        end else if (en_i) begin
            if (div_q == '0) begin
                // Halted: restart straight away once a new divisor is waiting.
                cnt_d  = '0;
                load_c = pending_q;
            end else if (cnt_q == div_last) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                level_d = ~level_q;
                load_c  = pending_q;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end

        // The load takes the shadow value present before this cycle's write.
        if (load_c) begin
            div_d     = shd_q;
            pending_d = 1'b0;
        end

        if (wr_i) begin
            shd_d     = wr_div_i;
            pending_d = 1'b1;
        end
    end

    // Channel state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q     <= WIDTH'(DEFAULT_DIV);
            shd_q     <= WIDTH'(DEFAULT_DIV);
            cnt_q     <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            shd_q     <= shd_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
        end
    end

    assign tick_o    = tick_q;
    assign level_o   = level_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider producing tick enables and 50% toggles.
module multi_clock_divider
    import clock_div_pkg::*;
#(
    parameter int unsigned CHANNELS    = DEF_CHANNELS,
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEFAULT_DIV = DEF_DIV,
    parameter int unsigned CH_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                cmosClock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync,
    input  logic                cfgWrite,
    input  logic [CH_BITS-1:0]  cfgChannel,
    input  logic [WIDTH-1:0]    cfgDivisor,
    output logic [CHANNELS-1:0] tickOut,
    output logic [CHANNELS-1:0] clockOut,
    output logic [CHANNELS-1:0] pending
);

    logic [CHANNELS-1:0] wr_sel;

    // Write decode; a channel index outside the populated range selects nothing.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (cfgWrite && (cfgChannel == CH_BITS'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        clock_div_channel #(
            .WIDTH      (WIDTH),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk_i    (cmosClock),
            .rst_i    (reset),
            .en_i     (enable[g]),
            .sync_i   (sync),
            .wr_i     (wr_sel[g]),
            .wr_div_i (cfgDivisor),
            .tick_o   (tickOut[g]),
            .level_o  (clockOut[g]),
            .pending_o(pending[g])
        );
    end

endmodule
